// File: rtl/segre_pkg.sv
// Shared types and stage indices for the segre core control unit.
// The stage indices fix the bit order of every per-stage vector.
package segre_pkg;

  localparam int NUM_STAGES = 5;
  localparam int STAGE_IF   = 0;
  localparam int STAGE_ID   = 1;
  localparam int STAGE_EX   = 2;
  localparam int STAGE_MEM  = 3;
  localparam int STAGE_WB   = 4;

  typedef enum logic [2:0] {
    IF_STATE,
    ID_STATE,
    EX_STATE,
    MEM_STATE,
    WB_STATE
  } fsm_state_e;

  typedef enum logic [2:0] {
    STALL_NONE,
    STALL_IF,
    STALL_HAZ,
    STALL_BR,
    STALL_MEM
  } stall_cause_e;

  // The multicycle states are numbered in stage order, so a state maps directly to a stage bit.
  function automatic logic [NUM_STAGES-1:0] stage_onehot(fsm_state_e s);
    return NUM_STAGES'(1) << s;
  endfunction

endpackage

// File: rtl/segre_pipeline_controller_if.sv
// Bundle between the control unit and the datapath: hit/hazard status in, per-stage control out.
// master is the controller side, slave the datapath side.
interface segre_pipeline_controller_if #(
  parameter int CNT_WIDTH = 32
);
  import segre_pkg::*;

  logic                  if_hit_i;
  logic                  mem_instr_i;
  logic                  dc_busy_i;
  logic                  dc_hit_i;
  logic                  raw_hazard_i;
  logic                  branch_taken_i;

  fsm_state_e            state_o;
  logic [NUM_STAGES-1:0] stage_valid_o;
  logic [NUM_STAGES-1:0] stage_en_o;
  logic [NUM_STAGES-1:0] flush_o;
  logic                  pc_redirect_o;
  stall_cause_e          stall_cause_o;
  logic [CNT_WIDTH-1:0]  stall_cnt_o;
  logic                  watchdog_o;

  modport master (
    input  if_hit_i, mem_instr_i, dc_busy_i, dc_hit_i, raw_hazard_i, branch_taken_i,
    output state_o, stage_valid_o, stage_en_o, flush_o, pc_redirect_o,
           stall_cause_o, stall_cnt_o, watchdog_o
  );

  modport slave (
    output if_hit_i, mem_instr_i, dc_busy_i, dc_hit_i, raw_hazard_i, branch_taken_i,
    input  state_o, stage_valid_o, stage_en_o, flush_o, pc_redirect_o,
           stall_cause_o, stall_cnt_o, watchdog_o
  );

endinterface

// File: rtl/segre_stall_monitor.sv
// Saturating count of stalled cycles plus a sticky watchdog on consecutive MEM-stall cycles.
// WDOG_CYCLES = 0 removes the watchdog entirely.
module segre_stall_monitor #(
  parameter int CNT_WIDTH   = 32,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 stall_i,
  input  logic                 mem_stall_i,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic                 watchdog_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stall_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stall_cnt_o = cnt_q;

  generate
    if (WDOG_CYCLES == 0) begin : g_no_wdog
      assign watchdog_o = 1'b0;
    end else begin : g_wdog
      localparam int RUN_W = $clog2(WDOG_CYCLES + 1);
      localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(WDOG_CYCLES);

      logic [RUN_W-1:0] run_q, run_d;
      logic             wdog_q, wdog_d;

      // The run length parks at the limit so a very long stall cannot wrap it.
      always_comb begin
        run_d = '0;
        if (mem_stall_i) run_d = (run_q == RUN_LIMIT) ? run_q : run_q + RUN_W'(1);
        wdog_d = wdog_q | (run_d == RUN_LIMIT);
      end

      always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
          run_q  <= '0;
          wdog_q <= 1'b0;
        end else begin
          run_q  <= run_d;
          wdog_q <= wdog_d;
        end
      end

      assign watchdog_o = wdog_q;
    end
  endgenerate

endmodule

// File: rtl/segre_pipeline_controller.sv
// Core control unit: either one-instruction-in-flight IF/ID/EX/MEM/WB sequencing or 5-stage
// pipeline control with stalls, branch flush, stall counter and MEM-stall watchdog.
module segre_pipeline_controller
  import segre_pkg::*;
#(
  parameter bit PIPELINED   = 1'b1,
  parameter int CNT_WIDTH   = 32,
  parameter int WDOG_CYCLES = 1024
) (
  input logic                         clk_i,
  input logic                         rsn_i,
  segre_pipeline_controller_if.master bus
);

  fsm_state_e            state;
  logic [NUM_STAGES-1:0] valid;
  logic [NUM_STAGES-1:0] en;
  logic [NUM_STAGES-1:0] flush;
  logic                  redirect;
  logic                  mem_st;
  stall_cause_e          cause;
  logic [CNT_WIDTH-1:0]  stall_cnt;
  logic                  watchdog;

  generate
    if (PIPELINED) begin : g_pipe
      logic [NUM_STAGES-1:0] valid_q, valid_d;
      logic                  mem_st_w, haz_st, if_st, br;

      always_ff @(posedge clk_i) begin
        if (!rsn_i) valid_q <= '0;
        else        valid_q <= valid_d;
      end

      always_comb begin
        mem_st_w = valid_q[STAGE_MEM] & (bus.dc_busy_i | (bus.mem_instr_i & ~bus.dc_hit_i));
        haz_st   = valid_q[STAGE_ID] & bus.raw_hazard_i;
        if_st    = valid_q[STAGE_IF] & ~bus.if_hit_i;
        br       = valid_q[STAGE_EX] & bus.branch_taken_i;

        valid_d  = {valid_q[NUM_STAGES-2:0], 1'b1};
        en       = '1;
        flush    = '0;
        redirect = 1'b0;
        cause    = STALL_NONE;

        if (mem_st_w) begin
          // Everything up to MEM freezes; a branch in EX waits there until MEM drains.
          en                  = '0;
          en[STAGE_WB]        = 1'b1;
          valid_d             = valid_q;
          valid_d[STAGE_WB]   = 1'b0;
          cause               = STALL_MEM;
        end else if (br) begin
          // The younger instruction in ID is squashed, so a hazard it raised is moot.
          redirect            = 1'b1;
          flush[STAGE_IF]     = 1'b1;
          flush[STAGE_ID]     = 1'b1;
          valid_d[STAGE_ID]   = 1'b0;
          valid_d[STAGE_EX]   = 1'b0;
          cause               = STALL_BR;
        end else if (haz_st) begin
          en[STAGE_IF]        = 1'b0;
          en[STAGE_ID]        = 1'b0;
          valid_d[STAGE_IF]   = valid_q[STAGE_IF];
          valid_d[STAGE_ID]   = valid_q[STAGE_ID];
          valid_d[STAGE_EX]   = 1'b0;
          cause               = STALL_HAZ;
        end else if (if_st) begin
          en[STAGE_IF]        = 1'b0;
          valid_d[STAGE_IF]   = valid_q[STAGE_IF];
          valid_d[STAGE_ID]   = 1'b0;
          cause               = STALL_IF;
        end
      end

      assign valid  = valid_q;
      assign state  = IF_STATE;
      assign mem_st = mem_st_w;
    end else begin : g_mc
      fsm_state_e state_q, state_d;
      logic       hold;

      always_ff @(posedge clk_i) begin
        if (!rsn_i) state_q <= IF_STATE;
        else        state_q <= state_d;
      end

      always_comb begin
        state_d = state_q;
        hold    = 1'b0;
        cause   = STALL_NONE;
        case (state_q)
          IF_STATE: begin
            if (bus.if_hit_i) state_d = ID_STATE;
            else              cause   = STALL_IF;
          end
          ID_STATE: state_d = EX_STATE;
          EX_STATE: state_d = MEM_STATE;
          MEM_STATE: begin
            if (bus.dc_busy_i | (bus.mem_instr_i & ~bus.dc_hit_i)) begin
              hold  = 1'b1;
              cause = STALL_MEM;
            end else begin
              state_d = WB_STATE;
            end
          end
          WB_STATE: state_d = IF_STATE;
          default:  state_d = IF_STATE;
        endcase
        en = (state_d != state_q) ? stage_onehot(state_d) : '0;
      end

      assign valid    = stage_onehot(state_q);
      assign flush    = '0;
      assign redirect = 1'b0;
      assign state    = state_q;
      assign mem_st   = hold;
    end
  endgenerate

  segre_stall_monitor #(
    .CNT_WIDTH  (CNT_WIDTH),
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_stall_monitor (
    .clk_i      (clk_i),
    .rsn_i      (rsn_i),
    .stall_i    (cause != STALL_NONE),
    .mem_stall_i(mem_st),
    .stall_cnt_o(stall_cnt),
    .watchdog_o (watchdog)
  );

  assign bus.state_o       = state;
  assign bus.stage_valid_o = valid;
  assign bus.stage_en_o    = en;
  assign bus.flush_o       = flush;
  assign bus.pc_redirect_o = redirect;
  assign bus.stall_cause_o = cause;
  assign bus.stall_cnt_o   = stall_cnt;
  assign bus.watchdog_o    = watchdog;

endmodule
